cpu_reset_monitor: RTL and testbench

Monitors the 68000's bidirectional /RESET and /HALT pins while the CPU drives them, which is the opposite direction to power-on reset generation.
- A 68000 RESET instruction (CPU drives /RESET low for 124 clocks) is qualified and turned into a stretched peripheral reset.
- A persistent CPU-driven /HALT (double bus fault) is timed, and a reboot request is raised to the power-on reset generator.
- Clocked by CPUCLK_IN. The system reset from the power-on generator is its RESET_IN.

---
 rtl/cpu_reset_monitor.sv | 119 +++++++++++
 tb/tb_cpu_reset_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_monitor.sv
// Watches the 68000 /RESET and /HALT pins while the CPU drives them: qualifies RESET
// instructions into a stretched peripheral reset and turns a stuck halt into a reboot request.
module cpu_reset_monitor #(
  parameter int MIN_RESET_CYCLES    = 100,
  parameter int PERIPH_RESET_CYCLES = 16,
  parameter int HALT_TIMEOUT        = 1000,
  parameter int CNT_W               = 16
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET_IN,
  input  logic       CPU_RESET_N_IN,
  input  logic       CPU_HALT_N_IN,
  output logic       PERIPH_RESET,
  output logic       CPU_HALTED,
  output logic       REBOOT_REQ,
  output logic [7:0] RESET_INSN_COUNT,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    QUALIFY    = 3'd1,
    PERIPH_RST = 3'd2,
    HALT_WATCH = 3'd3,
    REBOOT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_RESET_CYCLES);
  localparam logic [CNT_W-1:0] PR_C  = CNT_W'(PERIPH_RESET_CYCLES);
  localparam logic [CNT_W-1:0] HT_C  = CNT_W'(HALT_TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rst_m, rst_s, halt_m, halt_s;

  assign dbg_state = state;

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state            <= IDLE;
      cnt              <= '0;
      rst_m            <= 1'b1;
      rst_s            <= 1'b1;
      halt_m           <= 1'b1;
      halt_s           <= 1'b1;
      PERIPH_RESET     <= 1'b0;
      CPU_HALTED       <= 1'b0;
      REBOOT_REQ       <= 1'b0;
      RESET_INSN_COUNT <= 8'd0;
    end else begin
      // Two-flop synchronisers for the asynchronous CPU pins.
      rst_m  <= CPU_RESET_N_IN;
      rst_s  <= rst_m;
      halt_m <= CPU_HALT_N_IN;
      halt_s <= halt_m;

      case (state)
        IDLE: begin
          if (!rst_s) begin
            state <= QUALIFY;
            cnt   <= ONE;
          end else if (!halt_s) begin
            state      <= HALT_WATCH;
            cnt        <= ONE;
            CPU_HALTED <= 1'b1;
          end
        end

        QUALIFY: begin
          // Reaching the threshold wins over a release seen on the same edge.
          if (cnt == MIN_C) begin
            state        <= PERIPH_RST;
            cnt          <= ONE;
            PERIPH_RESET <= 1'b1;
            if (RESET_INSN_COUNT != 8'hFF) RESET_INSN_COUNT <= RESET_INSN_COUNT + 8'd1;
          end else if (rst_s) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        PERIPH_RST: begin
          // Pulse is at least PERIPH_RESET_CYCLES and stretches while /RESET stays low.
          if (cnt == PR_C && rst_s) begin
            state        <= IDLE;
            PERIPH_RESET <= 1'b0;
          end else if (cnt != PR_C) begin
            cnt <= cnt + ONE;
          end
        end

        HALT_WATCH: begin
          if (!rst_s) begin
            state      <= QUALIFY;
            cnt        <= ONE;
            CPU_HALTED <= 1'b0;
          end else if (halt_s) begin
            state      <= IDLE;
            CPU_HALTED <= 1'b0;
          end else if (cnt == HT_C) begin
            state      <= REBOOT;
            REBOOT_REQ <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        REBOOT: begin
          // Terminal until the power-on generator asserts RESET_IN.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_reset_monitor.sv
// Directed plus random stimulus for cpu_reset_monitor, checked every cycle against a
// behavioural run-length model of the pin rules.
module tb_cpu_reset_monitor;

  localparam int MIN_R = 100;
  localparam int PR_W  = 16;
  localparam int H_TO  = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       cpu_reset_n = 1'b1;
  logic       cpu_halt_n = 1'b1;
  logic       periph_reset, cpu_halted, reboot_req;
  logic [7:0] insn_count;
  logic [2:0] dbg_state;

  cpu_reset_monitor #(
    .MIN_RESET_CYCLES(MIN_R), .PERIPH_RESET_CYCLES(PR_W), .HALT_TIMEOUT(H_TO), .CNT_W(16)
  ) dut (
    .CPUCLK_IN(clk), .RESET_IN(rst), .CPU_RESET_N_IN(cpu_reset_n), .CPU_HALT_N_IN(cpu_halt_n),
    .PERIPH_RESET(periph_reset), .CPU_HALTED(cpu_halted), .REBOOT_REQ(reboot_req),
    .RESET_INSN_COUNT(insn_count), .dbg_state(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins pass through a 2-entry delay line; decisions come from run lengths of low samples.
  logic mq_rst[$];
  logic mq_halt[$];
  int   m_rrun, m_hrun, m_age, m_count;
  bit   m_pr, m_halted, m_reboot;

  function automatic void model_reset();
    mq_rst  = {1'b1, 1'b1};
    mq_halt = {1'b1, 1'b1};
    m_rrun = 0; m_hrun = 0; m_age = 0; m_count = 0;
    m_pr = 0; m_halted = 0; m_reboot = 0;
  endfunction

  function automatic void model_edge(input logic r_in, input logic h_in, input logic sys_rst);
    logic rs, hs;
    if (sys_rst) begin
      model_reset();
    end else begin
      rs = mq_rst.pop_front();
      mq_rst.push_back(r_in);
      hs = mq_halt.pop_front();
      mq_halt.push_back(h_in);
      if (m_reboot) begin
        // only a system reset ends a reboot request
      end else if (m_pr) begin
        if (m_age >= PR_W && rs) m_pr = 0;
        else m_age++;
      end else if (m_rrun > 0) begin
        if (m_rrun == MIN_R) begin
          m_pr = 1; m_age = 1; m_rrun = 0;
          if (m_count < 255) m_count++;
        end else if (rs) m_rrun = 0;
        else m_rrun++;
      end else if (!rs) begin
        m_rrun = 1; m_halted = 0; m_hrun = 0;
      end else if (m_halted) begin
        if (hs) m_halted = 0;
        else if (m_hrun == H_TO) m_reboot = 1;
        else m_hrun++;
      end else if (!hs) begin
        m_halted = 1; m_hrun = 1;
      end
    end
    exp_q.push_back({m_pr, m_halted | m_reboot, m_reboot, 8'(m_count)});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [10:0] e;
    @(posedge clk);
    model_edge(cpu_reset_n, cpu_halt_n, rst);
    cyc++;
    #1;
    e = exp_q.pop_front();
    check("periph_reset", {7'd0, periph_reset}, {7'd0, e[10]});
    check("cpu_halted", {7'd0, cpu_halted}, {7'd0, e[9]});
    check("reboot_req", {7'd0, reboot_req}, {7'd0, e[8]});
    check("insn_count", insn_count, e[7:0]);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Drive one pin low for low_n edges then high for tail_n; report the first rise/fall
  // edge of the matching output (-1 if none) relative to absolute cycle numbers.
  task automatic pulse_in(input bit on_halt, input int low_n, input int tail_n,
                          output longint e, output longint rise, output longint fall);
    logic mon;
    rise = -1; fall = -1; e = cyc + 1;
    if (on_halt) cpu_halt_n = 1'b0; else cpu_reset_n = 1'b0;
    for (int i = 0; i < low_n + tail_n; i++) begin
      if (i == low_n) begin
        if (on_halt) cpu_halt_n = 1'b1; else cpu_reset_n = 1'b1;
      end
      tick();
      mon = on_halt ? cpu_halted : periph_reset;
      if (mon && rise < 0) rise = cyc;
      else if (!mon && rise >= 0 && fall < 0) fall = cyc;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  longint e, rise, fall, hrise;
  int     kind, len;

  initial begin
    model_reset();

    // Reset state and quiet idle.
    rst = 1'b1; run(4);
    check("reset_periph", {7'd0, periph_reset}, 8'd0);
    check("reset_count", insn_count, 8'd0);
    rst = 1'b0; run(200);
    check("idle_periph", {7'd0, periph_reset}, 8'd0);
    check("idle_halted", {7'd0, cpu_halted}, 8'd0);

    // Genuine RESET instruction.
    pulse_in(1'b0, 124, 40, e, rise, fall);
    check_int("insn_rise_edge", rise, e + MIN_R + 2);
    check_int("insn_width_min", longint'(fall - rise >= PR_W), 1);
    check("insn_count_1", insn_count, 8'd1);

    // Glitches below threshold, then exactly at threshold.
    pulse_in(1'b0, 50, 20, e, rise, fall);
    check_int("glitch50_no_rise", rise, -1);
    pulse_in(1'b0, 99, 20, e, rise, fall);
    check_int("glitch99_no_rise", rise, -1);
    check("glitch_count", insn_count, 8'd1);
    pulse_in(1'b0, 100, 30, e, rise, fall);
    check_int("exact100_rise", rise, e + MIN_R + 2);
    check_int("exact100_width", fall - rise, PR_W);
    check("exact100_count", insn_count, 8'd2);

    // Transient halt, then a stuck halt.
    pulse_in(1'b1, 500, 10, e, rise, fall);
    check_int("halt500_width", fall - rise, 500);
    check("halt500_no_reboot", {7'd0, reboot_req}, 8'd0);
    cpu_halt_n = 1'b0; e = cyc + 1; hrise = -1;
    for (int i = 0; i < 1100 && hrise < 0; i++) begin
      tick();
      if (reboot_req) hrise = cyc;
    end
    check_int("reboot_rise_edge", hrise, e + H_TO + 2);
    run(5000);
    check("reboot_held", {7'd0, reboot_req}, 8'd1);
    check("reboot_halted", {7'd0, cpu_halted}, 8'd1);
    cpu_halt_n = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    check("post_reboot_req", {7'd0, reboot_req}, 8'd0);
    check("post_reboot_count", insn_count, 8'd0);
    run(10);

    // Halt interrupted by a RESET instruction.
    cpu_halt_n = 1'b0; run(300);
    check("halt_before_reset", {7'd0, cpu_halted}, 8'd1);
    cpu_reset_n = 1'b0; e = cyc + 1; rise = -1;
    for (int i = 0; i < 124; i++) begin
      if (i == 60) cpu_halt_n = 1'b1;
      tick();
      if (periph_reset && rise < 0) rise = cyc;
    end
    cpu_reset_n = 1'b1; run(40);
    check_int("halt_reset_rise", rise, e + MIN_R + 2);
    check("halt_reset_halted", {7'd0, cpu_halted}, 8'd0);
    check("halt_reset_count", insn_count, 8'd1);
    check("halt_reset_no_reboot", {7'd0, reboot_req}, 8'd0);

    // Saturation of the instruction counter.
    repeat (260) pulse_in(1'b0, 100, 22, e, rise, fall);
    check("count_saturated", insn_count, 8'd255);

    // System reset in the middle of a peripheral reset pulse.
    cpu_reset_n = 1'b0; run(MIN_R + 5);
    check("mid_pulse_high", {7'd0, periph_reset}, 8'd1);
    rst = 1'b1; tick(); rst = 1'b0; cpu_reset_n = 1'b1;
    check("mid_pulse_cut", {7'd0, periph_reset}, 8'd0);
    check("mid_pulse_count", insn_count, 8'd0);
    run(10);

    // Randomised pin activity.
    repeat (40) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: pulse_in(1'b0, $urandom_range(90, 110), $urandom_range(0, 30), e, rise, fall);
        1: pulse_in(1'b0, $urandom_range(1, 130), $urandom_range(0, 30), e, rise, fall);
        2: pulse_in(1'b1, $urandom_range(1, 1100), $urandom_range(0, 30), e, rise, fall);
        3: begin
          len = $urandom_range(1, 400);
          pulse_in(1'b1, len, 0, e, rise, fall);
          pulse_in(1'b0, $urandom_range(60, 130), $urandom_range(0, 30), e, rise, fall);
          cpu_halt_n = 1'b1;
        end
        4: begin
          rst = 1'b1; run($urandom_range(1, 3)); rst = 1'b0;
        end
        default: run($urandom_range(1, 30));
      endcase
      run($urandom_range(0, 20));
    end
    rst = 1'b1; tick(); rst = 1'b0; run(5);
    check("final_reboot", {7'd0, reboot_req}, 8'd0);

    $display("final monitor state code %0d", dbg_state);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
